// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: groups the byte handshake, raw PS/2 pin inputs, open-drain enables and status
// of the PS/2 host transmitter into one bundle.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (clock inhibit, request-to-send, shift, device ack).
// Optional macro PS2_TX_ACK_CHECK_EN turns a device NACK into an error pulse instead of done.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE
  } state_t;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          r_state;
  logic [1:0]      r_clkSync;
  logic [1:0]      r_dataSync;
  logic            r_clkPrev;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [3:0]      r_bitCnt;
  logic [CW-1:0]   r_cnt;
  logic            r_clkOe;
  logic            r_dataOe;
  logic            r_done;
  logic            r_error;
`ifdef PS2_TX_ACK_CHECK_EN
  logic            r_nack;
`endif
  logic            w_fe;
  logic            w_timeout;
  logic            w_busIdle;

  // Synchronizers reset to 1 so an idle (pulled-up) bus never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], bus.ps2_clk_in};
      r_dataSync <= {r_dataSync[0], bus.ps2_data_in};
      r_clkPrev  <= r_clkSync[1];
    end
  end

  assign w_fe      = r_clkPrev & ~r_clkSync[1];
  assign w_timeout = (int'(r_cnt) == TIMEOUT_CYCLES - 1);
  assign w_busIdle = r_clkSync[1] & r_dataSync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_bitCnt <= '0;
      r_cnt    <= '0;
      r_clkOe  <= 1'b0;
      r_dataOe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      r_nack   <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clkOe  <= 1'b0;
          r_dataOe <= 1'b0;
          if (bus.tx_valid) begin
            r_shift  <= bus.tx_data;
            r_par    <= ~^bus.tx_data;
            r_bitCnt <= '0;
            r_cnt    <= '0;
            r_clkOe  <= 1'b1;
            r_dataOe <= (INHIBIT_CYCLES == 1);
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (int'(r_cnt) + 2 == INHIBIT_CYCLES) r_dataOe <= 1'b1;
          if (int'(r_cnt) + 1 >= INHIBIT_CYCLES) begin
            r_clkOe  <= 1'b0;
            r_dataOe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_fe) begin
            r_dataOe <= ~r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitCnt <= 4'd1;
            r_cnt    <= '0;
            r_state  <= S_SHIFT;
          end else if (w_timeout) begin
            r_dataOe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // r_bitCnt holds how many falling edges have been seen so far in the frame.
        S_SHIFT: begin
          if (w_fe) begin
            r_cnt    <= '0;
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt < 4'd8) begin
              r_dataOe <= ~r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
            end else if (r_bitCnt == 4'd8) begin
              r_dataOe <= ~r_par;
            end else begin
              r_dataOe <= 1'b0;
              r_state  <= S_ACK;
            end
          end else if (w_timeout) begin
            r_dataOe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACK: begin
          if (w_fe) begin
`ifdef PS2_TX_ACK_CHECK_EN
            r_nack   <= r_dataSync[1];
`endif
            r_bitCnt <= r_bitCnt + 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WAITIDLE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAITIDLE: begin
          if (w_busIdle) begin
`ifdef PS2_TX_ACK_CHECK_EN
            r_done  <= ~r_nack;
            r_error <= r_nack;
`else
            r_done  <= 1'b1;
`endif
            r_state <= S_IDLE;
          end else if (w_fe) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_clkOe  <= 1'b0;
          r_dataOe <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready    = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.ps2_clk_oe  = r_clkOe;
  assign bus.ps2_data_oe = r_dataOe;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives random and directed bytes through ps2_host_tx against a PS/2 device model;
// a scoreboard queue of predicted frame outcomes is checked whenever done or error pulses.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 100;
  localparam int H   = 8;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         expErr;
    bit         checkFrame;
    int         expCycle;
  } exp_t;

  logic clk;
  logic rst;
  logic devClk;
  logic devDrive;
  logic cap [1:11];
  int   cycleCnt = 0;
  int   nVectors = 0;
  int   nMiscompares = 0;
  exp_t expQ[$];

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Open-drain wired-AND of host and device on both lines.
  assign bus.ps2_clk_in  = ~bus.ps2_clk_oe & devClk;
  assign bus.ps2_data_in = ~bus.ps2_data_oe & ~devDrive;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  function automatic exp_t predict(input logic [7:0] d, input bit nack, input bit timeout, input int a);
    exp_t e;
    e.data       = d;
    e.checkFrame = !timeout;
    e.expErr     = timeout || (ACK_CHECK && nack);
    e.expCycle   = timeout ? a + INH + TO : -1;
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input bit nack, input bit timeout,
                               input bit holdValid, output int acceptCycle);
    int waitCnt = 0;
    acceptCycle = -1;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && waitCnt < 3 * TO + INH + 400) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.tx_ready) begin
      checkOutput("acceptWait", 0, 1);
      bus.tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acceptCycle = cycleCnt;
    expQ.push_back(predict(d, nack, timeout, acceptCycle));
    bus.tx_valid = holdValid;
  endtask

  task automatic checkRequestTiming(input int a);
    int dataRise = -1;
    int clkFall  = -1;
    @(negedge clk);
    checkOutput("clkOeAfterAccept", bus.ps2_clk_oe, 1);
    checkOutput("busyAfterAccept", bus.busy, 1);
    checkOutput("readyAfterAccept", bus.tx_ready, 0);
    for (int i = 0; i < INH + 10 && clkFall < 0; i++) begin
      if (dataRise < 0 && bus.ps2_data_oe) dataRise = cycleCnt;
      if (dataRise >= 0 && !bus.ps2_clk_oe) clkFall = cycleCnt;
      if (clkFall < 0) @(negedge clk);
    end
    checkOutput("startBitCycle", dataRise, a + INH - 1);
    checkOutput("clkReleaseCycle", clkFall, a + INH);
  endtask

  // Device side: waits for request-to-send, then clocks 11 edges and reads bits on rising edges.
  task automatic runDevice(input bit enable, input bit nack, input int stallEdge, input int abortEdge);
    int waitCnt = 0;
    int hiCycles;
    while (!(bus.busy && !bus.ps2_clk_oe && bus.ps2_data_oe) && waitCnt < INH + 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("requestSeen", (bus.busy && !bus.ps2_clk_oe && bus.ps2_data_oe) ? 1 : 0, 1);
    if (!enable) return;
    repeat (5) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      devClk = 1'b0;
      repeat (H) @(negedge clk);
      if (e == abortEdge) return;
      cap[e] = bus.ps2_data_in;
      devClk = 1'b1;
      if (e == 11) begin
        devDrive = 1'b0;
        return;
      end
      hiCycles = (e == stallEdge) ? (TO - 1 - H) : H;
      @(negedge clk);
      if (e == 10) devDrive = !nack;
      repeat (hiCycles - 1) @(negedge clk);
    end
  endtask

  task automatic waitDrained();
    int waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 3 * TO + 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drainWait", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  task automatic runFrame(input logic [7:0] d, input bit nack, input int stallEdge);
    int a;
    applyStimulus(d, nack, 1'b0, 1'b0, a);
    runDevice(1'b1, nack, stallEdge, 0);
    waitDrained();
  endtask

  // Monitor: every done/error pulse consumes one prediction from the scoreboard.
  initial begin
    exp_t e;
    logic [7:0] capByte;
    forever begin
      @(negedge clk);
      if (!rst && (bus.done || bus.error)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("doneFlag", bus.done, e.expErr ? 0 : 1);
          checkOutput("errorFlag", bus.error, e.expErr ? 1 : 0);
          checkOutput("busyAtEnd", bus.busy, 0);
          checkOutput("readyAtEnd", bus.tx_ready, 1);
          checkOutput("linesReleased", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
          if (e.expCycle >= 0) checkOutput("endCycle", cycleCnt, e.expCycle);
          if (e.checkFrame) begin
            for (int i = 0; i < 8; i++) capByte[i] = cap[i + 1];
            checkOutput("frameData", capByte, e.data);
            checkOutput("frameParity", cap[9], ($countones(e.data) % 2 == 0) ? 1 : 0);
            checkOutput("frameStop", cap[10], 1);
          end
        end
      end
    end
  end

  initial begin
    int a;
    logic [7:0] d;
    bit nack;
    rst          = 1'b1;
    devClk       = 1'b1;
    devDrive     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetReady", bus.tx_ready, 1);
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetClkOe", bus.ps2_clk_oe, 0);
    checkOutput("resetDataOe", bus.ps2_data_oe, 0);
    checkOutput("resetDone", bus.done, 0);
    checkOutput("resetError", bus.error, 0);

    $display("[TB] send 0xED with request timing checks");
    applyStimulus(8'hED, 1'b0, 1'b0, 1'b0, a);
    checkRequestTiming(a);
    runDevice(1'b1, 1'b0, 0, 0);
    waitDrained();

    $display("[TB] back-to-back 0x01, 0xFF, 0x00 with tx_valid held");
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, a);
    bus.tx_data = 8'hFF;
    runDevice(1'b1, 1'b0, 0, 0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, a);
    bus.tx_data = 8'h00;
    runDevice(1'b1, 1'b0, 0, 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, a);
    runDevice(1'b1, 1'b0, 0, 0);
    waitDrained();

    $display("[TB] device never clocks");
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, a);
    runDevice(1'b0, 1'b0, 0, 0);
    waitDrained();

    $display("[TB] device NACK");
    runFrame(8'h5A, 1'b1, 0);

    $display("[TB] stall between edges 4 and 5");
    runFrame(8'h3C, 1'b0, 4);

    $display("[TB] reset after edge 5");
    d = 8'($urandom_range(0, 255)) & 8'hEF;
    applyStimulus(d, 1'b0, 1'b0, 1'b0, a);
    runDevice(1'b1, 1'b0, 0, 5);
    checkOutput("dataOeBeforeReset", bus.ps2_data_oe, 1);
    expQ.delete();
    rst = 1'b1;
    #1;
    checkOutput("midResetClkOe", bus.ps2_clk_oe, 0);
    checkOutput("midResetDataOe", bus.ps2_data_oe, 0);
    checkOutput("midResetReady", bus.tx_ready, 1);
    devClk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    runFrame(8'hF4, 1'b0, 0);

    $display("[TB] random frames");
    for (int i = 0; i < 5; i++) begin
      d    = 8'($urandom_range(0, 255));
      nack = ($urandom_range(0, 3) == 0);
      runFrame(d, nack, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
